// File: rtl/ring_ready_tracker_pkg.sv
// Shared constants and pointer type for the ring ready tracker.
package ring_ready_tracker_pkg;

    localparam int DEF_BUFFER_WIDTH    = 2;
    localparam int DEF_BUFFER_SIZE     = 4;
    localparam int DEF_ALMOST_FULL_LVL = 3;

    // Ring pointer: wrap parity above the slot index. Comparing two of these
    // separates full (same index, different round) from empty (identical).
    typedef struct packed {
        logic                        round;
        logic [DEF_BUFFER_WIDTH-1:0] idx;
    } ptr_t;

endpackage

// File: rtl/ring_ready_tracker_ptr.sv
// ring_ptr: slot index plus round bit, advancing modulo BufferSize.
module ring_ptr
    import ring_ready_tracker_pkg::*;
#(
    parameter int BufferWidth = DEF_BUFFER_WIDTH,
    parameter int BufferSize  = DEF_BUFFER_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   adv,
    output logic [BufferWidth-1:0] idx,
    output logic                   round
);

    localparam logic [BufferWidth-1:0] LastIdx = BufferWidth'(BufferSize - 1);

    logic [BufferWidth-1:0] idx_d, idx_q;
    logic                   round_d, round_q;

    // Next pointer: flush wins, otherwise step and toggle round on wrap.
    always_comb begin
        idx_d   = idx_q;
        round_d = round_q;
        if (flush) begin
            idx_d   = '0;
            round_d = 1'b0;
        end else if (adv) begin
            if (idx_q == LastIdx) begin
                idx_d   = '0;
                round_d = ~round_q;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Pointer register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            round_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            round_q <= round_d;
        end
    end

    assign idx   = idx_q;
    assign round = round_q;

endmodule

// File: rtl/ring_ready_tracker.sv
// ring_ready_tracker: write/read pointers of a ring buffer with a registered
// per-slot ready map, occupancy count and full/empty/almost_full flags.
module ring_ready_tracker
    import ring_ready_tracker_pkg::*;
#(
    parameter int BufferWidth   = DEF_BUFFER_WIDTH,
    parameter int BufferSize    = DEF_BUFFER_SIZE,
    parameter int AlmostFullLvl = DEF_ALMOST_FULL_LVL
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   rd_en,
    output logic                   rd_valid,
    output logic [BufferWidth-1:0] W_Addr,
    output logic [BufferWidth-1:0] R_Addr,
    output logic                   W_Round,
    output logic                   R_Round,
    output logic [BufferSize-1:0]  Ready,
    output logic [BufferWidth:0]   count,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full
);

    localparam logic [BufferWidth:0] AfLvl = (BufferWidth + 1)'(AlmostFullLvl);

    logic                  wr_acc, rd_acc;
    logic [BufferSize-1:0] ready_d, ready_q;
    logic [BufferWidth:0]  count_d, count_q;
    logic                  almost_full_d, almost_full_q;

    // Handshakes qualify only on registered flags, so ready/valid never
    // depend combinationally on wr_valid or rd_en.
    assign wr_acc = wr_valid & ~full;
    assign rd_acc = rd_en & ~empty;

    ring_ptr #(.BufferWidth(BufferWidth), .BufferSize(BufferSize)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .adv   (wr_acc),
        .idx   (W_Addr),
        .round (W_Round)
    );

    ring_ptr #(.BufferWidth(BufferWidth), .BufferSize(BufferSize)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .adv   (rd_acc),
        .idx   (R_Addr),
        .round (R_Round)
    );

    // Flags straight from the pointer registers.
    assign empty    = (W_Addr == R_Addr) && (W_Round == R_Round);
    assign full     = (W_Addr == R_Addr) && (W_Round != R_Round);
    assign wr_ready = ~full;
    assign rd_valid = ~empty;

    // Next ready map / count; a write and read can never hit the same slot
    // in one cycle since that would need the ring both full and empty.
    always_comb begin
        ready_d = ready_q;
        count_d = count_q;
        if (flush) begin
            ready_d = '0;
            count_d = '0;
        end else begin
            if (wr_acc) ready_d[W_Addr] = 1'b1;
            if (rd_acc) ready_d[R_Addr] = 1'b0;
            if (wr_acc && !rd_acc) count_d = count_q + 1'b1;
            if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
        end
        almost_full_d = (count_d >= AfLvl);
    end

    // Ready map, count and almost_full update on the pointer edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q       <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            ready_q       <= ready_d;
            count_q       <= count_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign Ready       = ready_q;
    assign count       = count_q;
    assign almost_full = almost_full_q;

endmodule

// File: tb/tb_ring_ready_tracker.sv
// Directed bench for ring_ready_tracker with default parameters.
module tb_ring_ready_tracker;

    logic       clk = 1'b0;
    logic       rst, flush, wr_valid, rd_en;
    logic       wr_ready, rd_valid, W_Round, R_Round, full, empty, almost_full;
    logic [1:0] W_Addr, R_Addr;
    logic [3:0] Ready;
    logic [2:0] count;

    int n_run  = 0;
    int n_fail = 0;

    ring_ready_tracker dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .rd_en       (rd_en),
        .rd_valid    (rd_valid),
        .W_Addr      (W_Addr),
        .R_Addr      (R_Addr),
        .W_Round     (W_Round),
        .R_Round     (R_Round),
        .Ready       (Ready),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Everything in its reset/empty state, pointers at the given slot/round.
    task automatic chk_idle(input string tag, input logic [1:0] ptr, input logic rnd);
        chk({tag, ".Ready"}, Ready, 4'b0000);
        chk({tag, ".count"}, count, 3'd0);
        chk({tag, ".empty"}, empty, 1'b1);
        chk({tag, ".full"}, full, 1'b0);
        chk({tag, ".af"}, almost_full, 1'b0);
        chk({tag, ".wr_ready"}, wr_ready, 1'b1);
        chk({tag, ".rd_valid"}, rd_valid, 1'b0);
        chk({tag, ".W_Addr"}, W_Addr, ptr);
        chk({tag, ".R_Addr"}, R_Addr, ptr);
        chk({tag, ".W_Round"}, W_Round, rnd);
        chk({tag, ".R_Round"}, R_Round, rnd);
    endtask

    logic [3:0] fill_exp [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

    initial begin
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_en = 1'b0;
        #12;
        chk_idle("reset", 2'd0, 1'b0);
        rst = 1'b0;

        // Fill four slots with no reads.
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("fill%0d.Ready", i), Ready, fill_exp[i]);
            chk($sformatf("fill%0d.count", i), count, 32'(i + 1));
            chk($sformatf("fill%0d.af", i), almost_full, (i >= 2));
        end
        chk("full.full", full, 1'b1);
        chk("full.wr_ready", wr_ready, 1'b0);
        chk("full.W_Addr", W_Addr, 2'd0);
        chk("full.W_Round", W_Round, 1'b1);

        // Full: write refused, read taken.
        rd_en = 1'b1;
        step();
        chk("fullrw.R_Addr", R_Addr, 2'd1);
        chk("fullrw.W_Addr", W_Addr, 2'd0);
        chk("fullrw.Ready", Ready, 4'b1110);
        chk("fullrw.count", count, 3'd3);
        chk("fullrw.full", full, 1'b0);
        chk("fullrw.af", almost_full, 1'b1);

        // Flush beats simultaneous write and read.
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_idle("flush", 2'd0, 1'b0);

        // Empty: write taken, read ignored.
        step();
        chk("emptyrw.Ready", Ready, 4'b0001);
        chk("emptyrw.count", count, 3'd1);
        chk("emptyrw.R_Addr", R_Addr, 2'd0);
        chk("emptyrw.W_Addr", W_Addr, 2'd1);
        chk("emptyrw.rd_valid", rd_valid, 1'b1);

        // Steady streaming: one slot in flight walking around the ring.
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("strm%0d.count", k), count, 3'd1);
            chk($sformatf("strm%0d.Ready", k), Ready, 4'b0001 << (k % 4));
            chk($sformatf("strm%0d.W_Addr", k), W_Addr, 32'((k + 1) % 4));
            chk($sformatf("strm%0d.R_Addr", k), R_Addr, 32'(k % 4));
            chk($sformatf("strm%0d.W_Round", k), W_Round, 32'(((k + 1) / 4) % 2));
            chk($sformatf("strm%0d.R_Round", k), R_Round, 32'((k / 4) % 2));
        end

        // Drain the last slot, then read while empty changes nothing.
        wr_valid = 1'b0;
        step();
        chk_idle("drain", 2'd3, 1'b0);
        step();
        chk_idle("rdempty", 2'd3, 1'b0);

        // Two writes, then asynchronous reset between edges.
        rd_en = 1'b0; wr_valid = 1'b1;
        step();
        step();
        wr_valid = 1'b0;
        chk("pre_rst.count", count, 3'd2);
        chk("pre_rst.Ready", Ready, 4'b1001);
        chk("pre_rst.W_Round", W_Round, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk_idle("async_rst", 2'd0, 1'b0);
        #2 rst = 1'b0;

        // First write after reset lands in slot 0.
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        chk("post_rst.Ready", Ready, 4'b0001);
        chk("post_rst.W_Addr", W_Addr, 2'd1);
        chk("post_rst.count", count, 3'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_ready_tracker.md
RING_READY_TRACKER -- requirements
Module: ring_ready_tracker

Interface
REQ-001 SHALL have parameter BufferWidth, default 2, slot-index width.
REQ-002 SHALL have parameter BufferSize, default 4, slot count; must equal 2**BufferWidth.
REQ-003 SHALL have parameter AlmostFullLvl, default 3, occupancy at or above which almost_full asserts.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous clear of all occupancy.
REQ-007 wr_valid  input  1  producer offers one slot write.
REQ-008 wr_ready  output  1  slot available (not full).
REQ-009 rd_en  input  1  consumer takes the oldest slot.
REQ-010 rd_valid  output  1  at least one unread slot (not empty).
REQ-011 W_Addr  output  BufferWidth  next slot to write.
REQ-012 R_Addr  output  BufferWidth  next slot to read.
REQ-013 W_Round, R_Round  output  1 each  wrap parity of each pointer.
REQ-014 Ready  output  BufferSize  bit i = 1 when slot i holds unread data.
REQ-015 count  output  BufferWidth+1  number of unread slots, 0..BufferSize.
REQ-016 full, empty, almost_full  output  1 each  occupancy flags.

Function
REQ-017 Write accepted on a clk edge when wr_valid && wr_ready: W_Addr increments modulo BufferSize; W_Round toggles when W_Addr wraps from BufferSize-1 to 0.
REQ-018 Read accepted on a clk edge when rd_en && rd_valid: R_Addr/R_Round advance identically; rd_en while empty is ignored with no state change.
REQ-019 empty = (W_Addr==R_Addr) && (W_Round==R_Round); full = (W_Addr==R_Addr) && (W_Round!=R_Round).
REQ-020 wr_ready = !full, rd_valid = !empty, both from registered state only (no combinational path from wr_valid/rd_en).
REQ-021 Ready is a register: bit W_Addr set on accepted write, bit R_Addr cleared on accepted read, same edge as pointer update; one cycle latency from handshake to Ready.
REQ-022 Ready SHALL at all times equal the occupancy map derived from W_Addr, R_Addr, W_Round, R_Round.
REQ-023 count is registered: +1 on write only, -1 on read only, unchanged on both or neither; count == popcount(Ready).
REQ-024 almost_full = (count >= AlmostFullLvl), registered with count.
REQ-025 Simultaneous accepted write and read: both pointers advance, count unchanged, Ready sets W_Addr bit and clears R_Addr bit.
REQ-026 Full: write rejected even if rd_en same cycle (wr_ready is low); read still accepted.
REQ-027 Empty: write accepted, rd_en same cycle ignored (no bypass); rd_valid rises next cycle.
REQ-028 flush has priority over wr/rd in the same cycle: pointers, rounds, Ready, count to 0; flags to empty state.

Reset
REQ-029 rst asserted SHALL asynchronously force W_Addr=0, R_Addr=0, W_Round=0, R_Round=0, Ready=0, count=0, empty=1, full=0, almost_full=0, wr_ready=1, rd_valid=0.
REQ-030 rst mid-operation SHALL discard all occupancy; first accepted write after deassertion targets slot 0.

Structure
REQ-031 Shared package holds default BufferWidth/BufferSize/AlmostFullLvl constants and a pointer type {round bit, BufferWidth index}.
REQ-032 One sub-module ring_ptr (index + round register with advance enable, wrap logic, flush, async reset), instantiated twice for write and read pointers.

Verification
REQ-033 Reset then 4 writes, no reads -> Ready 0001,0011,0111,1111; count 4; full=1; wr_ready=0; W_Addr=0, W_Round=1.
REQ-034 From full, wr_valid+rd_en same cycle -> only read accepted; R_Addr=1, Ready=1110, count=3, full=0.
REQ-035 Steady wr+rd every cycle for 10 cycles after one prefill write -> count stays 1; pointers wrap twice; rounds toggle each wrap; Ready single moving bit.
REQ-036 Empty with rd_en=1 and wr_valid=1 -> next cycle Ready=0001, count=1, R_Addr unchanged at 0.
REQ-037 count=3, flush with wr_valid and rd_en high -> next cycle all zero, empty=1, almost_full=0.
REQ-038 rst asserted between edges with count=2 -> outputs at reset values immediately, before next clk edge.
